issue_ctrl: RTL and testbench
=============================

Name: issue_ctrl

Overview:
- Dual-issue gate directly downstream of the decoded-instruction FIFO.
- Each cycle it inspects the two head instructions (slot0 = older) and decides how many issue in order: 0, 1 or 2.
- The decision drives the FIFO read count and the backend issue valids.
- It keeps a register scoreboard for long-latency producers (loads, mul/div), plus an outstanding-op limiter and stall/issue performance counters.

Parameters:
- MAX_OUTSTANDING, 4: maximum long-latency results in flight at once.
- PERF_WIDTH, 32: width of each performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- inst_valid_i  in  2  head instruction valid per slot (bit0 = slot0)
- r_reg0_i  in  2x5  first source register per slot
- r_reg1_i  in  2x5  second source register per slot
- w_reg_i  in  2x5  destination register per slot (0 = no write)
- long_lat_i  in  2  slot's result returns via the wb port, not the bypass network
- mem_i  in  2  slot uses the single LSU
- single_i  in  2  slot must issue alone (priv/CSR/branch-with-side-effect/idle)
- backend_stall_i  in  1  backend cannot accept this cycle
- flush_i  in  1  pipeline flush
- wb_valid_i  in  2  long-latency writeback valid per port
- wb_reg_i  in  2x5  writeback register per port
- issue_num_o  out  2  instructions issued this cycle (0..2); drives FIFO read_num
- issue_valid_o  out  2  thermometer form of issue_num_o ({num==2, num!=0})
- busy_o  out  32  scoreboard snapshot (debug)
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight long-latency count
- stall_cnt_o  out  PERF_WIDTH  cycles with inst_valid_i[0]=1 and issue_num_o=0
- issue_cnt_o  out  PERF_WIDTH  total instructions issued

Behaviour:
- Reset (rst_n=0 at posedge): busy=0, outstanding=0, both counters=0.
- issue_num_o and issue_valid_o are combinational and forced to 0 while rst_n=0, flush_i=1 or backend_stall_i=1.
- busy[0] is hardwired 0; sources or destinations equal to r0 never create hazards.

Slot0 issues iff all of:
- inst_valid_i[0]=1.
- Neither source busy.
- w_reg busy implies stall (WAW ordering).
- If long_lat_i[0]: outstanding < MAX_OUTSTANDING.

Slot1 issues iff all of:
- Slot0 issues and inst_valid_i[1]=1.
- single_i[0]=0 and single_i[1]=0.
- Not both mem_i set.
- Neither slot1 source equals a nonzero w_reg_i[0] (intra-pair RAW).
- w_reg_i[1] not equal to a nonzero w_reg_i[0].
- Slot1 sources and destination not busy.
- outstanding + long_lat_i[0] + long_lat_i[1] <= MAX_OUTSTANDING.

Scoreboard update at each posedge (not in reset):
- Flush: flush_i=1 clears busy to 0 and outstanding to 0; wb in the same cycle is ignored.
- Clear: for each wb_valid_i[k] with wb_reg_i[k]!=0, clear that busy bit.
- Set: for each issued slot with long_lat_i=1 and w_reg!=0, set that busy bit. Set wins over a same-cycle clear of the same register.
- Outstanding next = outstanding + (issued long-latency slots with w_reg!=0) - (distinct wb registers whose busy bit was 1 before the edge). Both wb ports naming the same register decrement once.
- Late wb: a wb to a non-busy register (e.g. arriving after a flush) changes nothing; outstanding never underflows.

Performance counters:
- issue_cnt: += issue_num_o each cycle.
- stall_cnt: +1 per qualifying cycle.
- Both wrap modulo 2^PERF_WIDTH and are not cleared by flush.

Test Plan:
- Reset, then slot0 ALU r1<-r2,r3 and slot1 ALU r4<-r5,r6, both valid -> issue_num_o=2, issue_valid_o=2'b11, issue_cnt_o=2 next cycle.
- Slot0 load r5 (long_lat) issues; next cycle slot0 reads r5 -> issue_num_o=0 and stall_cnt increments each cycle. Then wb_valid_i=01, wb_reg_i[0]=5 -> busy_o[5]=0 next cycle and the consumer issues on that cycle.
- Pair slot0 r7<-.., slot1 reads r7 -> issue_num_o=1. Same with w_reg_i[0]=0 and slot1 reading r0 -> issue_num_o=2.
- Issue 4 independent loads (r1..r4), then a 5th load -> outstanding_o=4 and issue_num_o=0. Wb r2 -> outstanding_o=3 and the 5th load issues.
- Load to r9 pending; same cycle: wb r9 and a new load to r9 issued -> busy_o[9]=1 afterwards, outstanding_o unchanged.
- Two loads outstanding, then flush_i=1 -> busy_o=0 and outstanding_o=0. A late wb to r3 afterwards -> outstanding_o stays 0. Also: single_i[0]=1 with both slots valid -> issue_num_o=1; backend_stall_i=1 -> issue_num_o=0.

Source files
------------

// File: rtl/issue_ctrl_if.sv
// Issue-gate bundle: decoded-instruction heads and writeback returns in, issue decision out.
// Latency: not applicable (wires only).
// Backpressure: carried by backend_stall_i and the issue count fed back to the FIFO.
//
// Ports (per slot/port, index 0 = older slot / wb port 0):
//   inst_valid_i, r_reg0_i, r_reg1_i, w_reg_i, long_lat_i, mem_i, single_i : head instructions
//   backend_stall_i, flush_i                                               : pipeline control
//   wb_valid_i, wb_reg_i                                                   : long-latency writebacks
//   issue_num_o, issue_valid_o                                             : issue decision
interface issue_ctrl_if;
    logic [1:0]      inst_valid_i;
    logic [1:0][4:0] r_reg0_i;
    logic [1:0][4:0] r_reg1_i;
    logic [1:0][4:0] w_reg_i;
    logic [1:0]      long_lat_i;
    logic [1:0]      mem_i;
    logic [1:0]      single_i;
    logic            backend_stall_i;
    logic            flush_i;
    logic [1:0]      wb_valid_i;
    logic [1:0][4:0] wb_reg_i;
    logic [1:0]      issue_num_o;
    logic [1:0]      issue_valid_o;

    // master: instruction FIFO / backend side
    modport master (
        output inst_valid_i, r_reg0_i, r_reg1_i, w_reg_i, long_lat_i, mem_i, single_i,
        output backend_stall_i, flush_i, wb_valid_i, wb_reg_i,
        input  issue_num_o, issue_valid_o
    );

    // slave: the issue gate
    modport slave (
        input  inst_valid_i, r_reg0_i, r_reg1_i, w_reg_i, long_lat_i, mem_i, single_i,
        input  backend_stall_i, flush_i, wb_valid_i, wb_reg_i,
        output issue_num_o, issue_valid_o
    );
endinterface

// File: rtl/issue_ctrl.sv
// Dual in-order issue gate with long-latency register scoreboard, outstanding limiter and perf counters.
// Latency: issue decision is combinational from the head instructions; scoreboard/counters update at posedge.
// Backpressure: backend_stall_i, flush_i or reset force zero issue; FIFO pops exactly issue_num_o entries.
//
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   ifc            : issue_ctrl_if.slave bundle (heads, control, writebacks, issue decision)
//   busy_o         : scoreboard snapshot, bit n = register n awaiting a long-latency result
//   outstanding_o  : long-latency results currently in flight
//   stall_cnt_o    : cycles with a valid slot0 that issued nothing
//   issue_cnt_o    : total instructions issued
module issue_ctrl #(
    parameter int  MAX_OUTSTANDING = 4,
    parameter int  PERF_WIDTH      = 32,
    localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    issue_ctrl_if.slave           ifc,
    output logic [31:0]           busy_o,
    output logic [OW-1:0]         outstanding_o,
    output logic [PERF_WIDTH-1:0] stall_cnt_o,
    output logic [PERF_WIDTH-1:0] issue_cnt_o
);

    logic [31:0]           busy_q;
    logic [OW-1:0]         out_q;
    logic [PERF_WIDTH-1:0] stall_cnt_q;
    logic [PERF_WIDTH-1:0] issue_cnt_q;

    logic        s0_ok, s1_ok, pair_dep, gate, iss0, iss1;
    logic [31:0] out_ext;
    logic [31:0] clr_mask, set_mask, busy_nxt;
    logic        set0, set1, dec0, dec1;
    logic [31:0] inc_ext, dec_ext, out_nxt_ext;
    logic [1:0]  issue_num;

    assign out_ext = 32'(out_q);

    // Issue decision
    always_comb begin
        // busy_q[0] is always 0, so r0 operands never look busy
        s0_ok = ifc.inst_valid_i[0]
             && !busy_q[ifc.r_reg0_i[0]] && !busy_q[ifc.r_reg1_i[0]]
             && !busy_q[ifc.w_reg_i[0]]
             && (!ifc.long_lat_i[0] || (out_ext < 32'(MAX_OUTSTANDING)));

        // slot1 may not read or overwrite what slot0 produces in the same pair
        pair_dep = (ifc.w_reg_i[0] != 5'd0)
                && ((ifc.r_reg0_i[1] == ifc.w_reg_i[0])
                 || (ifc.r_reg1_i[1] == ifc.w_reg_i[0])
                 || (ifc.w_reg_i[1]  == ifc.w_reg_i[0]));

        s1_ok = s0_ok && ifc.inst_valid_i[1]
             && !ifc.single_i[0] && !ifc.single_i[1]
             && !(ifc.mem_i[0] && ifc.mem_i[1])
             && !pair_dep
             && !busy_q[ifc.r_reg0_i[1]] && !busy_q[ifc.r_reg1_i[1]]
             && !busy_q[ifc.w_reg_i[1]]
             && ((out_ext + 32'(ifc.long_lat_i[0]) + 32'(ifc.long_lat_i[1]))
                 <= 32'(MAX_OUTSTANDING));

        gate = rst_n && !ifc.flush_i && !ifc.backend_stall_i;
        iss0 = gate && s0_ok;
        iss1 = gate && s1_ok;

        issue_num = {iss1, iss0 && !iss1};
    end

    assign ifc.issue_num_o   = issue_num;
    assign ifc.issue_valid_o = {iss1, iss0};

    // Scoreboard next state
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        for (int k = 0; k < 2; k++) begin
            if (ifc.wb_valid_i[k] && (ifc.wb_reg_i[k] != 5'd0))
                clr_mask[ifc.wb_reg_i[k]] = 1'b1;
        end

        set0 = iss0 && ifc.long_lat_i[0] && (ifc.w_reg_i[0] != 5'd0);
        set1 = iss1 && ifc.long_lat_i[1] && (ifc.w_reg_i[1] != 5'd0);
        if (set0) set_mask[ifc.w_reg_i[0]] = 1'b1;
        if (set1) set_mask[ifc.w_reg_i[1]] = 1'b1;

        // Only writebacks that retire a real in-flight result count; a second
        // port naming the same register is the same retirement.
        dec0 = ifc.wb_valid_i[0] && (ifc.wb_reg_i[0] != 5'd0) && busy_q[ifc.wb_reg_i[0]];
        dec1 = ifc.wb_valid_i[1] && (ifc.wb_reg_i[1] != 5'd0) && busy_q[ifc.wb_reg_i[1]]
            && !(dec0 && (ifc.wb_reg_i[1] == ifc.wb_reg_i[0]));

        // set applied after clear so a same-cycle reissue keeps the bit
        busy_nxt    = (busy_q & ~clr_mask) | set_mask;
        busy_nxt[0] = 1'b0;

        inc_ext     = 32'(set0) + 32'(set1);
        dec_ext     = 32'(dec0) + 32'(dec1);
        out_nxt_ext = out_ext + inc_ext;
        if (out_nxt_ext >= dec_ext)
            out_nxt_ext = out_nxt_ext - dec_ext;
        else
            out_nxt_ext = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= '0;
            out_q       <= '0;
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            if (ifc.flush_i) begin
                busy_q <= '0;
                out_q  <= '0;
            end else begin
                busy_q <= busy_nxt;
                out_q  <= OW'(out_nxt_ext);
            end
            issue_cnt_q <= issue_cnt_q + PERF_WIDTH'(issue_num);
            if (ifc.inst_valid_i[0] && (issue_num == 2'd0))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign busy_o        = busy_q;
    assign outstanding_o = out_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign issue_cnt_o   = issue_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: vector table for the pairing rules, hand sequences for scoreboard corners.
// Latency: checks combinational issue one cycle-phase after drive, registered state #1 after posedge.
// Backpressure: exercised through backend_stall_i and flush_i vectors.
module tb_issue_ctrl;
    localparam int MAXO = 4;
    localparam int PW   = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    issue_ctrl_if ifc ();

    logic [31:0]   busy;
    logic [2:0]    outst;
    logic [PW-1:0] stall_cnt;
    logic [PW-1:0] issue_cnt;

    issue_ctrl #(.MAX_OUTSTANDING(MAXO), .PERF_WIDTH(PW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifc           (ifc),
        .busy_o        (busy),
        .outstanding_o (outst),
        .stall_cnt_o   (stall_cnt),
        .issue_cnt_o   (issue_cnt)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [PW-1:0] exp_issue = '0;
    logic [PW-1:0] exp_stall = '0;

    typedef struct {
        logic [1:0]      vld;
        logic [1:0][4:0] ra, rb, rw;
        logic [1:0]      mem, sgl;
        logic            stall, flush;
        int              expn;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] vld,
                                input logic [4:0] a0, b0, w0, a1, b1, w1,
                                input logic [1:0] mem, sgl,
                                input logic stall, flush, input int expn);
        vec_t v;
        v.vld = vld;  v.ra = {a1, a0};  v.rb = {b1, b0};  v.rw = {w1, w0};
        v.mem = mem;  v.sgl = sgl;  v.stall = stall;  v.flush = flush;
        v.expn = expn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle();
        ifc.inst_valid_i    = '0;
        ifc.r_reg0_i        = '0;
        ifc.r_reg1_i        = '0;
        ifc.w_reg_i         = '0;
        ifc.long_lat_i      = '0;
        ifc.mem_i           = '0;
        ifc.single_i        = '0;
        ifc.backend_stall_i = 1'b0;
        ifc.flush_i         = 1'b0;
        ifc.wb_valid_i      = '0;
        ifc.wb_reg_i        = '0;
    endtask

    task automatic slot(input int s, input logic [4:0] a, b, w, input logic lng, mem, sgl);
        ifc.inst_valid_i[s] = 1'b1;
        ifc.r_reg0_i[s]     = a;
        ifc.r_reg1_i[s]     = b;
        ifc.w_reg_i[s]      = w;
        ifc.long_lat_i[s]   = lng;
        ifc.mem_i[s]        = mem;
        ifc.single_i[s]     = sgl;
    endtask

    // Check this cycle's issue decision, update the counter model, advance one clock.
    task automatic step(input string nm, input int expn);
        logic [1:0] ev;
        #1;
        ev = {expn == 2, expn != 0};
        chk({nm, " num"}, ifc.issue_num_o, expn);
        chk({nm, " vld"}, ifc.issue_valid_o, ev);
        exp_issue += PW'(expn);
        if (ifc.inst_valid_i[0] && expn == 0) exp_stall += 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        slot(0, 5'd2, 5'd3, 5'd1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst num", ifc.issue_num_o, 0);
        chk("rst busy", busy, 0);
        chk("rst outst", outst, 0);
        chk("rst issue_cnt", issue_cnt, 0);
        chk("rst stall_cnt", stall_cnt, 0);
        idle();
        rst_n = 1'b1;

        // Pairing rules with an empty scoreboard; no long-latency ops here
        vecs.push_back(mk(2'b11, 2,3,1,  5,6,4,  2'b00, 2'b00, 0, 0, 2)); // independent ALU pair
        vecs.push_back(mk(2'b11, 1,2,7,  7,3,8,  2'b00, 2'b00, 0, 0, 1)); // slot1 src0 reads r7
        vecs.push_back(mk(2'b11, 1,2,0,  0,0,8,  2'b00, 2'b00, 0, 0, 2)); // r0 dest/src no hazard
        vecs.push_back(mk(2'b11, 1,2,7,  3,4,7,  2'b00, 2'b00, 0, 0, 1)); // intra-pair WAW
        vecs.push_back(mk(2'b11, 1,2,3,  4,5,6,  2'b00, 2'b01, 0, 0, 1)); // slot0 single
        vecs.push_back(mk(2'b11, 1,2,3,  4,5,6,  2'b00, 2'b10, 0, 0, 1)); // slot1 single
        vecs.push_back(mk(2'b11, 1,2,3,  4,5,6,  2'b11, 2'b00, 0, 0, 1)); // both need LSU
        vecs.push_back(mk(2'b11, 1,2,3,  4,5,6,  2'b01, 2'b00, 0, 0, 2)); // one LSU user
        vecs.push_back(mk(2'b10, 1,2,3,  4,5,6,  2'b00, 2'b00, 0, 0, 0)); // slot0 empty
        vecs.push_back(mk(2'b01, 1,2,3,  4,5,6,  2'b00, 2'b00, 0, 0, 1)); // only slot0
        vecs.push_back(mk(2'b11, 1,2,3,  4,5,6,  2'b00, 2'b00, 1, 0, 0)); // backend stall
        vecs.push_back(mk(2'b11, 1,2,3,  4,5,6,  2'b00, 2'b00, 0, 1, 0)); // flush
        vecs.push_back(mk(2'b11, 1,2,0,  3,4,0,  2'b00, 2'b00, 0, 0, 2)); // both dests r0
        vecs.push_back(mk(2'b11, 1,2,7,  3,7,8,  2'b00, 2'b00, 0, 0, 1)); // slot1 src1 reads r7

        for (int i = 0; i < vecs.size(); i++) begin
            idle();
            ifc.inst_valid_i    = vecs[i].vld;
            ifc.r_reg0_i        = vecs[i].ra;
            ifc.r_reg1_i        = vecs[i].rb;
            ifc.w_reg_i         = vecs[i].rw;
            ifc.mem_i           = vecs[i].mem;
            ifc.single_i        = vecs[i].sgl;
            ifc.backend_stall_i = vecs[i].stall;
            ifc.flush_i         = vecs[i].flush;
            step($sformatf("vec%0d", i), vecs[i].expn);
            chk($sformatf("vec%0d issue_cnt", i), issue_cnt, exp_issue);
            chk($sformatf("vec%0d stall_cnt", i), stall_cnt, exp_stall);
        end

        // Load r5, dependent consumer waits for its writeback
        idle(); slot(0, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0);
        step("ld r5", 1);
        chk("ld r5 busy", busy[5], 1);
        chk("ld r5 outst", outst, 1);
        idle(); slot(0, 5'd5, 5'd1, 5'd10, 1'b0, 1'b0, 1'b0);
        step("raw r5 c1", 0);
        step("raw r5 c2", 0);
        chk("raw r5 stall_cnt", stall_cnt, exp_stall);
        idle(); slot(0, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0, 1'b0);
        slot(1, 5'd5, 5'd1, 5'd12, 1'b0, 1'b0, 1'b0);
        step("s1 busy src", 1);
        idle(); slot(0, 5'd5, 5'd1, 5'd10, 1'b0, 1'b0, 1'b0);
        ifc.wb_valid_i = 2'b01; ifc.wb_reg_i[0] = 5'd5;
        step("wb r5 cycle", 0);
        chk("wb r5 busy", busy[5], 0);
        chk("wb r5 outst", outst, 0);
        ifc.wb_valid_i = 2'b00;
        step("consumer", 1);

        // Outstanding limiter
        idle(); slot(0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0); slot(1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        step("ld r1 r2", 2);
        idle(); slot(0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0); slot(1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        step("ld r3 r4", 2);
        chk("lim outst4", outst, 4);
        chk("lim busy", busy, 32'h0000_001E);
        idle(); slot(0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0);
        step("ld5 blocked", 0);
        ifc.wb_valid_i = 2'b10; ifc.wb_reg_i[1] = 5'd2;
        step("ld5 wb r2", 0);
        chk("wb r2 outst", outst, 3);
        chk("wb r2 busy", busy, 32'h0000_001A);
        idle(); slot(0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0); slot(1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        step("ld pair at 3", 1);
        chk("refill outst", outst, 4);
        idle(); slot(0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        step("waw busy dest", 0);

        // Flush clears scoreboard; same-cycle and late writebacks are ignored
        idle(); slot(0, 5'd1, 5'd2, 5'd8, 1'b0, 1'b0, 1'b0);
        ifc.flush_i = 1'b1; ifc.wb_valid_i = 2'b01; ifc.wb_reg_i[0] = 5'd1;
        step("flush", 0);
        chk("flush busy", busy, 0);
        chk("flush outst", outst, 0);
        idle(); ifc.wb_valid_i = 2'b01; ifc.wb_reg_i[0] = 5'd3;
        step("late wb", 0);
        chk("late wb outst", outst, 0);
        chk("late wb busy", busy, 0);

        // Both wb ports naming one register retire it once
        idle(); slot(0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0); slot(1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
        step("ld r9 r10", 2);
        chk("r9r10 outst", outst, 2);
        idle(); ifc.wb_valid_i = 2'b11; ifc.wb_reg_i = {5'd9, 5'd9};
        step("dual wb r9", 0);
        chk("dual wb outst", outst, 1);
        chk("dual wb busy", busy, 32'h0000_0400);

        // Retire r10 while a stale wb to r12 coincides with issuing a load to r12
        idle(); slot(0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0);
        ifc.wb_valid_i = 2'b11; ifc.wb_reg_i = {5'd12, 5'd10};
        step("set vs clr r12", 1);
        chk("set wins busy", busy, 32'h0000_1000);
        chk("set wins outst", outst, 1);

        idle();
        chk("final issue_cnt", issue_cnt, exp_issue);
        chk("final stall_cnt", stall_cnt, exp_stall);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
